// File: rtl/disp_value_fmt_pkg.sv
// Shared constants and state type for the display value formatter.
package disp_pkg;
  localparam int          DISP_DIGITS     = 4;
  localparam logic [15:0] DISP_DEC_MAX    = 16'd9999;
  localparam int          DISP_CONV_ITERS = 16;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } disp_state_e;
endpackage

// File: rtl/disp_value_fmt_bcd_adj3.sv
// Double-dabble digit corrector: adds 3 to a BCD nibble of 5 or more.
module bcd_adj3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/disp_value_fmt.sv
// Formats a 16-bit value into four digit codes (hex, or decimal via double-dabble).
// The decimal path exists only when DISP_DEC_EN is defined; otherwise every write is hex.
module disp_value_fmt
  import disp_pkg::*;
#(
  parameter logic [3:0] OVF_DIGIT = 4'hE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic        dec_mode,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [3:0]  bcd0,
  output logic [3:0]  bcd1,
  output logic [3:0]  bcd2,
  output logic [3:0]  bcd3
);

  logic [15:0] digits_q, digits_d;
  logic        done_q, done_d;

`ifdef DISP_DEC_EN
  disp_state_e state_q, state_d;
  logic [15:0] bin_q, bin_d;
  logic [15:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic [15:0] acc_adj;
  logic [31:0] shifted;

  for (genvar g = 0; g < DISP_DIGITS; g++) begin : g_adj
    bcd_adj3 u_adj (
      .din  (acc_q[4*g +: 4]),
      .dout (acc_adj[4*g +: 4])
    );
  end

  assign shifted = {acc_adj, bin_q} << 1;

  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    digits_d = digits_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_en) begin
          ovf_d = 1'b0;
          if (!dec_mode) begin
            digits_d = wr_data;
            done_d   = 1'b1;
          end else if (wr_data > DISP_DEC_MAX) begin
            digits_d = {DISP_DIGITS{OVF_DIGIT}};
            ovf_d    = 1'b1;
            done_d   = 1'b1;
          end else begin
            bin_d   = wr_data;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = CONV;
          end
        end
      end
      CONV: begin
        acc_d = shifted[31:16];
        bin_d = shifted[15:0];
        cnt_d = cnt_q + 4'd1;
        // Last iteration publishes the shifted accumulator directly.
        if (cnt_q == 4'(DISP_CONV_ITERS - 1)) begin
          digits_d = shifted[31:16];
          done_d   = 1'b1;
          ovf_d    = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == CONV);
  assign overflow = ovf_q;
`else
  logic unused_dec_mode;

  assign unused_dec_mode = dec_mode;

  always_comb begin
    digits_d = digits_q;
    done_d   = 1'b0;
    if (wr_en) begin
      digits_d = wr_data;
      done_d   = 1'b1;
    end
  end

  assign busy     = 1'b0;
  assign overflow = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digits_q <= '0;
      done_q   <= 1'b0;
    end else begin
      digits_q <= digits_d;
      done_q   <= done_d;
    end
  end

  assign done = done_q;
  assign bcd0 = digits_q[3:0];
  assign bcd1 = digits_q[7:4];
  assign bcd2 = digits_q[11:8];
  assign bcd3 = digits_q[15:12];

endmodule

// File: doc/disp_value_fmt.md
# disp_value_fmt

Formats a 16-bit value written by the core into the four 4-bit digit codes (`bcd0`..`bcd3`) consumed by the seven-segment scanner. It sits directly upstream of the scanner. Hex mode passes nibbles straight through. Decimal mode runs an iterative shift-add-3 (double-dabble) conversion. Outputs hold their previous digits until a conversion completes, so the display never shows partial results.

## Interface
- `OVF_DIGIT`, default `4'hE`: digit code driven on all four digits when a decimal value is out of range.
- `clk` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `wr_en` in 1: write strobe; `wr_data` is sampled on an edge where `wr_en=1` and `busy=0`.
- `wr_data` in 16: value to display.
- `dec_mode` in 1: sampled with `wr_data`; 1 = decimal, 0 = hex.
- `busy` out 1: decimal conversion in progress; writes are ignored while high.
- `done` out 1: one-cycle pulse; the digit outputs were updated on the previous edge.
- `overflow` out 1: last accepted decimal write was greater than 9999; cleared by the next accepted write.
- `bcd0` out 4: least-significant digit.
- `bcd1` out 4: digit 1.
- `bcd2` out 4: digit 2.
- `bcd3` out 4: most-significant digit.

## Operation
- Reset (asynchronous, `reset=0`):
  - `bcd0`..`bcd3` = 0, `busy` = 0, `done` = 0, `overflow` = 0.
  - State goes to IDLE. Any in-flight conversion is discarded.
- State machine: IDLE, CONV.
- IDLE, accepted write, hex mode (`dec_mode=0`):
  - `bcd0`..`bcd3` take `wr_data[3:0]`, `[7:4]`, `[11:8]`, `[15:12]` respectively.
  - `done` = 1, `overflow` = 0. State stays IDLE.
- IDLE, accepted write, decimal mode, `wr_data > 9999`:
  - All digits = `OVF_DIGIT`, `overflow` = 1, `done` = 1. State stays IDLE.
- IDLE, accepted write, decimal mode, `wr_data <= 9999`:
  - Load the 16-bit binary shift register, clear the 16-bit BCD accumulator, set the 4-bit iteration counter to 0.
  - `busy` = 1. Go to CONV.
- Each CONV edge (one iteration):
  - Every accumulator nibble that is 5 or greater gets +3.
  - Then shift {accumulator, binary} left by 1.
  - Counter increments.
- CONV edge with counter = 15:
  - The post-iteration accumulator is loaded straight into `bcd0`..`bcd3`.
  - `done` = 1, `overflow` = 0, `busy` = 0. Go to IDLE.
- Arithmetic: the accumulator is exactly 16 bits. The range check guarantees no carry out of `bcd3`. Nibbles never exceed 9 after the final iteration.
- A write on an edge where `busy=1` is dropped silently: no queueing, no error flag.
- `dec_mode` and `wr_data` are ignored outside an accepting edge.
- Reset deasserting mid-conversion: the block restarts in IDLE with zero digits; the interrupted value is never displayed.

## Timing
- Hex or overflow write accepted at edge T:
  - Digits and `overflow` valid after T.
  - `done` high for cycle T..T+1.
  - `busy` stays 0.
- Decimal write accepted at edge T:
  - `busy` high after T through edge T+16.
  - Edges T+1..T+16 are the 16 iterations.
  - Digits valid after T+16; `done` high for cycle T+16..T+17.
- Earliest next accepted write: edge T+17. A write at T+16 is ignored because `busy` is still 1 before that edge.
- Throughput: 1 write per cycle in hex mode; 1 per 17 cycles in decimal mode.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `DISP_DEC_EN` defined:
  - Decimal path, CONV state, range check and `overflow` logic are compiled in.
- `DISP_DEC_EN` undefined:
  - `dec_mode` is ignored and every write takes the hex path.
  - `busy` and `overflow` are tied to 0.
  - No CONV state or accumulator is generated.

## Structure
- Shared package `disp_pkg`:
  - constant `DISP_DIGITS=4`
  - constant `DISP_DEC_MAX=16'd9999`
  - constant `DISP_CONV_ITERS=16`
  - state type with IDLE and CONV
- One sub-module, `bcd_adj3`: 4-bit combinational digit corrector (adds 3 if input is 5 or greater). Instantiate it once per digit.

## Test plan
- Hex mode: write `16'hBEEF` at edge T -> after T, `bcd3..0` = B,E,E,F; `done` = 1 for one cycle; `busy` = 0 throughout.
- Decimal mode: write 1234 at edge T -> `busy` = 1 for cycles T+1..T+16; digits stay at their previous value until T+16; then 1,2,3,4 with a `done` pulse.
- Decimal boundaries:
  - 0 -> 0,0,0,0.
  - 9999 -> 9,9,9,9 with `overflow` = 0.
  - 10000 and 65535 -> E,E,E,E with `overflow` = 1 and no `busy`.
- Busy drop: write 4321 during the conversion of 1234 -> final digits are 1,2,3,4 and only one `done` pulse. A write at T+17 is accepted.
- Reset at T+8 mid-conversion -> all digits 0, `busy`/`done`/`overflow` = 0 immediately; no `done` pulse afterward.
- `DISP_DEC_EN` undefined: write 1234 (`16'h04D2`) with `dec_mode=1` -> digits 0,4,D,2 after one edge; `busy` never asserts.
